// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: loadable instruction memory, PC sequencing,
// one-cycle fetch latency, jump redirect with a single bubble, stall hold
// and halt-on-opcode detection. Memory contents survive reset.
module instruction_fetch_unit #(
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Stall,
  input  logic                         Is_Branch,
  input  logic                         Load_En,
  input  logic [$clog2(MEM_DEPTH)-1:0] Load_Addr,
  input  logic [31:0]                  Load_Data,
  output logic [31:0]                  Instruction_Code,
  output logic [31:0]                  PC_Out,
  output logic                         Valid,
  output logic                         Halted
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [5:0] HALT_OP = 6'b111111;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr_nx, pc_out_nx;
  logic        valid_nx;
  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] fetch_word;

  // Word index ignores the upper PC bits, so fetches wrap around the memory.
  assign fetch_word = mem[pc[AW+1:2]];
  assign Halted     = (state == HALT);

  // Memory is only writable while idle; it has no reset so a program
  // loaded once can be re-run after Reset.
  always_ff @(posedge Clk) begin
    if (!Reset && state == IDLE && Load_En)
      mem[Load_Addr] <= Load_Data;
  end

  // Next-state and next-output selection; everything holds by default,
  // which also gives the Stall behaviour for free.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    instr_nx  = Instruction_Code;
    pc_out_nx = PC_Out;
    valid_nx  = Valid;
    case (state)
      IDLE: begin
        if (Start) begin
          state_nx = RUN;
          pc_nx    = RESET_PC;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (Is_Branch && Valid) begin
            // Jump target keeps the region bits of the sequential successor
            // of the jump; the word fetched this cycle is dropped.
            pc_nx    = ((PC_Out + 32'd4) & 32'hF000_0000) |
                       {4'b0000, Instruction_Code[25:0], 2'b00};
            instr_nx = 32'd0;
            valid_nx = 1'b0;
          end else if (fetch_word[31:26] == HALT_OP) begin
            // Halt word is never issued; PC stays parked on it.
            state_nx  = HALT;
            instr_nx  = 32'd0;
            valid_nx  = 1'b0;
            pc_out_nx = pc;
          end else begin
            instr_nx  = fetch_word;
            pc_out_nx = pc;
            valid_nx  = 1'b1;
            pc_nx     = pc + 32'd4;
          end
        end
      end
      HALT: begin
        instr_nx = 32'd0;
        valid_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      Instruction_Code <= 32'd0;
      PC_Out           <= 32'd0;
      Valid            <= 1'b0;
    end else begin
      state            <= state_nx;
      pc               <= pc_nx;
      Instruction_Code <= instr_nx;
      PC_Out           <= pc_out_nx;
      Valid            <= valid_nx;
    end
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, meaning instruction memory depth in 32-bit words (power of 2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset and on Start.
REQ-003 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port Start  input  1  begin fetching from RESET_PC; honoured only in IDLE.
REQ-006 SHALL have port Stall  input  1  hold all fetch state and outputs this cycle.
REQ-007 SHALL have port Is_Branch  input  1  jump decoded from the current Instruction_Code by the downstream decoder.
REQ-008 SHALL have port Load_En  input  1  instruction memory write strobe; honoured only in IDLE.
REQ-009 SHALL have port Load_Addr  input  log2(MEM_DEPTH)  word index for memory write.
REQ-010 SHALL have port Load_Data  input  32  word written to memory.
REQ-011 SHALL have port Instruction_Code  output  32  registered instruction to the decoder; 32'd0 is a NOP bubble.
REQ-012 SHALL have port PC_Out  output  32  byte address of the word in Instruction_Code.
REQ-013 SHALL have port Valid  output  1  Instruction_Code holds a fetched word, not a bubble.
REQ-014 SHALL have port Halted  output  1  high while in HALT state.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALT; reset state IDLE.
REQ-016 IDLE: Load_En=1 SHALL write Load_Data to Mem[Load_Addr] at the clock edge; Start=1 SHALL set PC=RESET_PC and go to RUN; Load_En and Start in the same cycle SHALL both take effect.
REQ-017 RUN, Stall=0, no branch: at each edge SHALL set Instruction_Code=Mem[PC[log2(MEM_DEPTH)+1:2]], PC_Out=PC, Valid=1, PC=PC+4 (32-bit, modulo 2^32).
REQ-018 Memory index SHALL use only PC[log2(MEM_DEPTH)+1:2]; addresses beyond the depth wrap to the start of memory.
REQ-019 Latency SHALL be one cycle from PC to Instruction_Code; first valid word appears on the second edge after Start is sampled.
REQ-020 RUN, Stall=0, Is_Branch=1 and Valid=1: SHALL set PC={PC_Out+4[31:28], Instruction_Code[25:0], 2'b00}, Instruction_Code=32'd0, Valid=0 (one-cycle bubble); the sequentially fetched word SHALL be discarded.
REQ-021 Is_Branch SHALL be ignored when Valid=0.
REQ-022 Stall=1 SHALL hold PC, Instruction_Code, PC_Out, Valid and state unchanged, overriding Is_Branch and halt.
REQ-023 When a word with opcode [31:26]=6'b111111 is fetched (Stall=0, no branch), SHALL enter HALT at the same edge, setting Instruction_Code=32'd0, Valid=0, PC_Out=address of the halt word; the halt word is not issued.
REQ-024 HALT SHALL assert Halted=1, hold PC, output bubbles, and ignore Start, Load_En, Is_Branch; exit only via Reset.
REQ-025 Load_En in RUN or HALT SHALL NOT modify memory.
REQ-026 Start in RUN SHALL be ignored.

Reset
REQ-027 Reset=1 at an edge SHALL set state=IDLE, PC=RESET_PC, Instruction_Code=0, PC_Out=0, Valid=0, Halted=0, in any state including mid-RUN and mid-stall.
REQ-028 Reset SHALL NOT clear instruction memory contents.
REQ-029 Reset SHALL take priority over Start, Stall, Load_En and Is_Branch.

Verification
REQ-030 Load Mem[0..2]=32'h2001_0005, 32'h2002_0007, 32'h0022_1820; Start -> Instruction_Code sequence matches, PC_Out=0,4,8, Valid=1 each cycle, one-cycle latency.
REQ-031 Mem[1]=32'h0800_0004, Mem[4]=32'h2003_0001; drive Is_Branch=1 while PC_Out=4 -> next Instruction_Code=0 with Valid=0, then 32'h2003_0001 with PC_Out=16.
REQ-032 Stall=1 for 3 cycles with PC_Out=8 -> outputs unchanged for 3 cycles; resume at PC_Out=12; Stall together with Is_Branch -> no redirect.
REQ-033 Mem[3]=32'hFC00_0000 -> Halted=1, Valid=0, PC_Out=12; Start and Load_En ignored while halted; Reset -> IDLE, memory intact.
REQ-034 MEM_DEPTH=64, run past word 63 -> PC_Out=256 presents Mem[0] contents.
REQ-035 Reset asserted mid-RUN -> all outputs zero next edge; Start -> refetch from RESET_PC with original memory contents.
